// File: rtl/accuracy_window_monitor.sv
// Scores each completed DNN case against its one-hot label and keeps a sliding
// window of recent hits, saturating running totals and epoch bookkeeping.
module accuracy_window_monitor #(
  parameter int NOUT            = 16,
  parameter int NVALID          = 10,
  parameter int WINDOW          = 1000,
  parameter int CASES_PER_EPOCH = 10000,
  parameter int CNT_W           = 32,
  localparam int RW = $clog2(WINDOW + 1),
  localparam int PW = $clog2(WINDOW),
  localparam int EW = (CASES_PER_EPOCH > 1) ? $clog2(CASES_PER_EPOCH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             case_done,
  input  logic [NOUT-1:0]  a_out,
  input  logic [NOUT-1:0]  y_ideal,
  output logic             correct,
  output logic             result_valid,
  output logic [RW-1:0]    recent,
  output logic             window_full,
  output logic [CNT_W-1:0] num_cases,
  output logic [CNT_W-1:0] total_correct,
  output logic [EW-1:0]    case_in_epoch,
  output logic [15:0]      epoch,
  output logic             epoch_done
);

  logic              hit;
  logic [WINDOW-1:0] win_buf;
  logic [PW-1:0]     ptr;

  assign hit = (a_out[NVALID-1:0] == y_ideal[NVALID-1:0]);

  // Label/output bits above NVALID are padding neurons and never affect the score.
  generate
    if (NVALID < NOUT) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^{a_out[NOUT-1:NVALID], y_ideal[NOUT-1:NVALID]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      correct       <= 1'b0;
      result_valid  <= 1'b0;
      recent        <= '0;
      window_full   <= 1'b0;
      num_cases     <= '0;
      total_correct <= '0;
      case_in_epoch <= '0;
      epoch         <= 16'd1;
      epoch_done    <= 1'b0;
      win_buf       <= '0;
      ptr           <= '0;
    end else begin
      result_valid <= 1'b0;
      epoch_done   <= 1'b0;
      if (case_done) begin
        correct      <= hit;
        result_valid <= 1'b1;
        // The displaced entry is read before it is overwritten; zeros before the first wrap.
        recent       <= recent - RW'(win_buf[ptr]) + RW'(hit);
        win_buf[ptr] <= hit;
        if (ptr == PW'(WINDOW - 1)) begin
          ptr         <= '0;
          window_full <= 1'b1;
        end else begin
          ptr <= ptr + 1'b1;
        end
        if (num_cases != {CNT_W{1'b1}})
          num_cases <= num_cases + 1'b1;
        if (hit && (total_correct != {CNT_W{1'b1}}))
          total_correct <= total_correct + 1'b1;
        if (case_in_epoch == EW'(CASES_PER_EPOCH - 1)) begin
          case_in_epoch <= '0;
          epoch         <= epoch + 16'd1;
          epoch_done    <= 1'b1;
        end else begin
          case_in_epoch <= case_in_epoch + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_accuracy_window_monitor.sv
// Directed bench for accuracy_window_monitor with a small window (8) and short epochs (4).
module tb_accuracy_window_monitor;

  localparam int NOUT = 16;
  localparam int NVALID = 10;
  localparam int WINDOW = 8;
  localparam int CPE = 4;
  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        case_done = 1'b0;
  logic [15:0] a_out = '0;
  logic [15:0] y_ideal = '0;
  logic        correct;
  logic        result_valid;
  logic [3:0]  recent;
  logic        window_full;
  logic [31:0] num_cases;
  logic [31:0] total_correct;
  logic [1:0]  case_in_epoch;
  logic [15:0] epoch;
  logic        epoch_done;

  int total = 0;
  int bad = 0;

  accuracy_window_monitor #(
    .NOUT(NOUT), .NVALID(NVALID), .WINDOW(WINDOW),
    .CASES_PER_EPOCH(CPE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .case_done(case_done), .a_out(a_out), .y_ideal(y_ideal),
    .correct(correct), .result_valid(result_valid), .recent(recent),
    .window_full(window_full), .num_cases(num_cases), .total_correct(total_correct),
    .case_in_epoch(case_in_epoch), .epoch(epoch), .epoch_done(epoch_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cd;
    logic [15:0] a;
    logic [15:0] y;
    logic        c;
    logic        rv;
    logic [3:0]  rec;
    logic [31:0] n;
    logic [31:0] t;
    logic [1:0]  cin;
    logic [15:0] ep;
    logic        ed;
    logic        full;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one case for one clock and leaves inputs stable until the next call.
  task automatic applyStimulus(input logic cd, input logic [15:0] a, input logic [15:0] y);
    case_done = cd;
    a_out = a;
    y_ideal = y;
    @(posedge clk);
    #1;
    case_done = 1'b0;
  endtask

  task automatic doReset();
    case_done = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h0001, 16'h0001, 1'b1, 1'b1, 4'd1, 32'd1, 32'd1, 2'd1, 16'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h0200, 16'h0200, 1'b1, 1'b1, 4'd2, 32'd2, 32'd2, 2'd2, 16'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h0010, 16'h0010, 1'b1, 1'b1, 4'd3, 32'd3, 32'd3, 2'd3, 16'd1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h000C, 16'h0004, 1'b0, 1'b1, 4'd3, 32'd4, 32'd3, 2'd0, 16'd2, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'hFC01, 16'h0001, 1'b1, 1'b1, 4'd4, 32'd5, 32'd4, 2'd1, 16'd2, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h1234, 16'h0001, 1'b1, 1'b0, 4'd4, 32'd5, 32'd4, 2'd1, 16'd2, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 16'h0000, 16'h0200, 1'b0, 1'b1, 4'd4, 32'd6, 32'd4, 2'd2, 16'd2, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 16'h0040, 16'h0040, 1'b1, 1'b1, 4'd5, 32'd7, 32'd5, 2'd3, 16'd2, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 16'h0100, 16'h0100, 1'b1, 1'b1, 4'd6, 32'd8, 32'd6, 2'd0, 16'd3, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1, 4'd5, 32'd9, 32'd6, 2'd1, 16'd3, 1'b0, 1'b1};

    // Reset state, while held and after release.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held_recent", 32'(recent), 32'd0);
    checkOutput("held_epoch", 32'(epoch), 32'd1);
    doReset();
    checkOutput("rst_recent", 32'(recent), 32'd0);
    checkOutput("rst_num", num_cases, 32'd0);
    checkOutput("rst_total", total_correct, 32'd0);
    checkOutput("rst_epoch", 32'(epoch), 32'd1);
    checkOutput("rst_full", 32'(window_full), 32'd0);
    checkOutput("rst_valid", 32'(result_valid), 32'd0);

    // Table: matches, a bit3 miss, ignored high bits, an idle cycle, window wrap, epoch rollovers.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].cd, vecs[i].a, vecs[i].y);
      checkOutput($sformatf("v%0d_correct", i), 32'(correct), 32'(vecs[i].c));
      checkOutput($sformatf("v%0d_valid", i), 32'(result_valid), 32'(vecs[i].rv));
      checkOutput($sformatf("v%0d_recent", i), 32'(recent), 32'(vecs[i].rec));
      checkOutput($sformatf("v%0d_num", i), num_cases, vecs[i].n);
      checkOutput($sformatf("v%0d_total", i), total_correct, vecs[i].t);
      checkOutput($sformatf("v%0d_cin", i), 32'(case_in_epoch), 32'(vecs[i].cin));
      checkOutput($sformatf("v%0d_epoch", i), 32'(epoch), 32'(vecs[i].ep));
      checkOutput($sformatf("v%0d_edone", i), 32'(epoch_done), 32'(vecs[i].ed));
      checkOutput($sformatf("v%0d_full", i), 32'(window_full), 32'(vecs[i].full));
    end
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput("idle_valid", 32'(result_valid), 32'd0);

    // Window: 8 hits then 2 misses.
    doReset();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 16'h0020, 16'h0020);
      checkOutput($sformatf("win_hit%0d_recent", i), 32'(recent), 32'(i));
      checkOutput($sformatf("win_hit%0d_full", i), 32'(window_full), (i == 8) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b1, 16'h0020, 16'h0040);
    checkOutput("win_miss1_recent", 32'(recent), 32'd7);
    applyStimulus(1'b1, 16'h0020, 16'h0040);
    checkOutput("win_miss2_recent", 32'(recent), 32'd6);
    checkOutput("win_miss2_full", 32'(window_full), 32'd1);
    checkOutput("win_total", total_correct, 32'd8);

    // Epoch: four back-to-back cases.
    doReset();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 16'h0002, 16'h0002);
      checkOutput($sformatf("ep_c%0d_valid", i), 32'(result_valid), 32'd1);
      checkOutput($sformatf("ep_c%0d_edone", i), 32'(epoch_done), (i == 4) ? 32'd1 : 32'd0);
    end
    checkOutput("ep_epoch", 32'(epoch), 32'd2);
    checkOutput("ep_cin", 32'(case_in_epoch), 32'd0);
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput("ep_idle_valid", 32'(result_valid), 32'd0);
    checkOutput("ep_idle_edone", 32'(epoch_done), 32'd0);

    // Async reset mid-burst after the window has wrapped once.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 16'h0008, 16'h0008);
    checkOutput("ar_pre_recent", 32'(recent), 32'd8);
    case_done = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_recent", 32'(recent), 32'd0);
    checkOutput("ar_num", num_cases, 32'd0);
    checkOutput("ar_full", 32'(window_full), 32'd0);
    checkOutput("ar_epoch", 32'(epoch), 32'd1);
    checkOutput("ar_valid", 32'(result_valid), 32'd0);
    case_done = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 16'h0008, 16'h0004);
    checkOutput("ar_miss_recent", 32'(recent), 32'd0);
    checkOutput("ar_miss_num", num_cases, 32'd1);
    checkOutput("ar_miss_correct", 32'(correct), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
